// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two requester handshakes and the shared RAM port.
// The arbiter takes the slave side; requesters and the RAM model take the master side.
interface ram_port_arbiter_if #(
   parameter int AW = 15,
   parameter int DW = 8
);
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;
   logic          cpu_stall;

   logic          ext_req;
   logic          ext_we;
   logic [AW-1:0] ext_addr;
   logic [DW-1:0] ext_wdata;
   logic [DW-1:0] ext_rdata;
   logic          ext_ack;
   logic          ext_lock;

   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic          ram_we;
   logic          ram_re;
   logic [DW-1:0] ram_rdata;

   logic          owner;
   logic          busy;

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
      output ram_rdata,
      input  cpu_rdata, cpu_ack, cpu_stall,
      input  ext_rdata, ext_ack,
      input  ram_addr, ram_wdata, ram_we, ram_re,
      input  owner, busy
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
      input  ram_rdata,
      output cpu_rdata, cpu_ack, cpu_stall,
      output ext_rdata, ext_ack,
      output ram_addr, ram_wdata, ram_we, ram_re,
      output owner, busy
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing the single-port RAM between the CPU datapath and the loader port.
// state  | meaning
// IDLE   | sample requests, arbitrate, latch the winner's fields
// STROBE | one-cycle ram_we/ram_re pulse from the latched fields
// WAIT   | read latency countdown; capture ram_rdata when the counter reads 0
// ACK    | one-cycle ack to the owner; requests not sampled
module ram_port_arbiter #(
   parameter int AW     = 15,
   parameter int DW     = 8,
   parameter int RD_LAT = 1
) (
   input  logic clk,
   input  logic rst_n,
   ram_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, STROBE, WAIT, ACK} state_t;

   localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

   state_t        state, state_nxt;
   logic          last_grant;
   logic [2:0]    cnt;
   logic          lat_we;
   logic [AW-1:0] lat_addr;
   logic [DW-1:0] lat_wdata;
   logic          own;
   logic [DW-1:0] cpu_rd, ext_rd;
   logic          grant_cpu, grant_ext, wait_done;
   logic          cpu_ack_i, ext_ack_i, ram_we_i, ram_re_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant_cpu = 1'b0;
      grant_ext = 1'b0;
      wait_done = 1'b0;
      ram_we_i  = 1'b0;
      ram_re_i  = 1'b0;
      cpu_ack_i = 1'b0;
      ext_ack_i = 1'b0;
      case (state)
         IDLE: begin
            // last_grant = 1 means ext won last time, so a conflict goes to the CPU
            if (bus.ext_lock) begin
               grant_ext = bus.ext_req;
            end else if (bus.cpu_req && bus.ext_req) begin
               grant_ext = ~last_grant;
               grant_cpu = last_grant;
            end else begin
               grant_cpu = bus.cpu_req;
               grant_ext = bus.ext_req;
            end
            if (grant_cpu || grant_ext) state_nxt = STROBE;
         end
         STROBE: begin
            ram_we_i  = lat_we;
            ram_re_i  = ~lat_we;
            state_nxt = lat_we ? ACK : WAIT;
         end
         WAIT: begin
            if (cnt == 3'd0) begin
               wait_done = 1'b1;
               state_nxt = ACK;
            end
         end
         ACK: begin
            cpu_ack_i = ~own;
            ext_ack_i = own;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 1'b1;
         cnt        <= 3'd0;
         lat_we     <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         own        <= 1'b0;
         cpu_rd     <= '0;
         ext_rd     <= '0;
      end else begin
         if (grant_cpu || grant_ext) begin
            lat_we     <= grant_ext ? bus.ext_we    : bus.cpu_we;
            lat_addr   <= grant_ext ? bus.ext_addr  : bus.cpu_addr;
            lat_wdata  <= grant_ext ? bus.ext_wdata : bus.cpu_wdata;
            own        <= grant_ext;
            last_grant <= grant_ext;
         end
         if (state == STROBE && !lat_we)
            cnt <= CNT_INIT;
         else if (state == WAIT && cnt != 3'd0)
            cnt <= cnt - 3'd1;
         if (wait_done) begin
            if (own) ext_rd <= bus.ram_rdata;
            else     cpu_rd <= bus.ram_rdata;
         end
      end
   end

   assign bus.ram_addr  = lat_addr;
   assign bus.ram_wdata = lat_wdata;
   assign bus.ram_we    = ram_we_i;
   assign bus.ram_re    = ram_re_i;
   assign bus.cpu_ack   = cpu_ack_i;
   assign bus.ext_ack   = ext_ack_i;
   assign bus.cpu_rdata = cpu_rd;
   assign bus.ext_rdata = ext_rd;
   assign bus.cpu_stall = bus.cpu_req & ~cpu_ack_i;
   assign bus.owner     = own;
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: vector table of single accesses plus
// hand sequences for round-robin, ext_lock, RD_LAT=3 timing and mid-access reset.
module tb_ram_port_arbiter;
   logic clk;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   ram_port_arbiter_if #(.AW(15), .DW(8)) a ();
   ram_port_arbiter_if #(.AW(15), .DW(8)) b ();

   ram_port_arbiter #(.AW(15), .DW(8), .RD_LAT(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(a)
   );
   ram_port_arbiter #(.AW(15), .DW(8), .RD_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .bus(b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model for the RD_LAT=1 instance; 0xEE marks "data not valid yet"
   logic [7:0] mem_a [0:32767];
   logic [7:0] pd_a;
   logic       pv_a;
   always @(posedge clk) begin
      if (a.ram_we) mem_a[a.ram_addr] <= a.ram_wdata;
      pv_a <= rst_n & a.ram_re;
      pd_a <= mem_a[a.ram_addr];
   end
   assign a.ram_rdata = pv_a ? pd_a : 8'hEE;

   // Read-only 3-cycle RAM model for the RD_LAT=3 instance
   logic [7:0] pd_b [0:2];
   logic [2:0] pv_b;
   always @(posedge clk) begin
      pv_b    <= rst_n ? {pv_b[1:0], b.ram_re} : 3'b000;
      pd_b[0] <= (b.ram_addr == 15'h0100) ? 8'h77 : 8'h00;
      pd_b[1] <= pd_b[0];
      pd_b[2] <= pd_b[1];
   end
   assign b.ram_rdata = pv_b[2] ? pd_b[2] : 8'hEE;

   typedef struct {
      bit         ext;
      bit         we;
      logic [14:0] addr;
      logic [7:0] wdata;
      int         lat;
      logic [7:0] cpu_rd;
      logic [7:0] ext_rd;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called one time unit after a rising edge with the arbiter in IDLE.
   task automatic run_access(input vec_t v, input int idx);
      int          lat;
      int          nstb;
      logic [14:0] sa;
      logic [7:0]  sd;
      logic        swe;
      logic        stall_ok;
      logic        stall_at_ack;
      logic        own;
      logic [7:0]  crd, erd;
      lat = -1; nstb = 0; sa = '0; sd = '0; swe = 1'b0;
      stall_ok = 1'b1; stall_at_ack = 1'b1; own = 1'b0; crd = '0; erd = '0;
      if (v.ext) begin
         a.ext_we = v.we; a.ext_addr = v.addr; a.ext_wdata = v.wdata; a.ext_req = 1'b1;
      end else begin
         a.cpu_we = v.we; a.cpu_addr = v.addr; a.cpu_wdata = v.wdata; a.cpu_req = 1'b1;
      end
      for (int c = 0; c < 20 && lat < 0; c++) begin
         @(negedge clk);
         if (a.ram_we || a.ram_re) begin
            nstb++; sa = a.ram_addr; sd = a.ram_wdata; swe = a.ram_we;
         end
         if (v.ext ? a.ext_ack : a.cpu_ack) begin
            lat = c; own = a.owner; crd = a.cpu_rdata; erd = a.ext_rdata;
            stall_at_ack = a.cpu_stall;
         end else if (!v.ext && !a.cpu_stall) begin
            stall_ok = 1'b0;
         end
      end
      @(posedge clk); #1;
      a.cpu_req = 1'b0;
      a.ext_req = 1'b0;
      chk($sformatf("v%0d ack latency", idx), lat, v.lat);
      chk($sformatf("v%0d strobe count", idx), nstb, 1);
      chk($sformatf("v%0d ram_addr", idx), {17'd0, sa}, {17'd0, v.addr});
      chk($sformatf("v%0d ram_we at strobe", idx), {31'd0, swe}, {31'd0, v.we});
      if (v.we) chk($sformatf("v%0d ram_wdata", idx), {24'd0, sd}, {24'd0, v.wdata});
      chk($sformatf("v%0d owner", idx), {31'd0, own}, {31'd0, v.ext});
      chk($sformatf("v%0d cpu_rdata", idx), {24'd0, crd}, {24'd0, v.cpu_rd});
      chk($sformatf("v%0d ext_rdata", idx), {24'd0, erd}, {24'd0, v.ext_rd});
      if (!v.ext) begin
         chk($sformatf("v%0d stall during access", idx), {31'd0, stall_ok}, 32'd1);
         chk($sformatf("v%0d stall in ack cycle", idx), {31'd0, stall_at_ack}, 32'd0);
      end
   endtask

   initial begin
      int   n;
      int   ext_acks;
      int   cpu_grants;
      logic stall_ok;
      logic seen;
      logic got_own;
      logic [0:3] order;
      logic any_ack;
      logic any_busy;

      vecs[0] = '{1'b0, 1'b1, 15'h0010, 8'hA5, 2, 8'h00, 8'h00};
      vecs[1] = '{1'b1, 1'b1, 15'h7FFF, 8'h3C, 2, 8'h00, 8'h00};
      vecs[2] = '{1'b1, 1'b0, 15'h7FFF, 8'h00, 3, 8'h00, 8'h3C};
      vecs[3] = '{1'b0, 1'b0, 15'h0010, 8'h00, 3, 8'hA5, 8'h3C};
      vecs[4] = '{1'b0, 1'b1, 15'h1234, 8'h5A, 2, 8'hA5, 8'h3C};
      vecs[5] = '{1'b1, 1'b0, 15'h1234, 8'h00, 3, 8'hA5, 8'h5A};
      vecs[6] = '{1'b0, 1'b0, 15'h7FFF, 8'h00, 3, 8'h3C, 8'h5A};
      vecs[7] = '{1'b1, 1'b1, 15'h0000, 8'hFF, 2, 8'h3C, 8'h5A};
      vecs[8] = '{1'b1, 1'b0, 15'h0000, 8'h00, 3, 8'h3C, 8'hFF};

      a.cpu_req = 0; a.cpu_we = 0; a.cpu_addr = '0; a.cpu_wdata = '0;
      a.ext_req = 0; a.ext_we = 0; a.ext_addr = '0; a.ext_wdata = '0; a.ext_lock = 0;
      b.cpu_req = 0; b.cpu_we = 0; b.cpu_addr = '0; b.cpu_wdata = '0;
      b.ext_req = 0; b.ext_we = 0; b.ext_addr = '0; b.ext_wdata = '0; b.ext_lock = 0;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset busy", {31'd0, a.busy}, 32'd0);
      chk("reset ram_we", {31'd0, a.ram_we}, 32'd0);
      chk("reset ram_re", {31'd0, a.ram_re}, 32'd0);
      chk("reset acks", {30'd0, a.cpu_ack, a.ext_ack}, 32'd0);
      chk("reset owner", {31'd0, a.owner}, 32'd0);
      chk("reset ram_addr", {17'd0, a.ram_addr}, 32'd0);
      chk("reset rdata", {16'd0, a.cpu_rdata, a.ext_rdata}, 32'd0);
      chk("reset busy rd_lat3", {31'd0, b.busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) run_access(vecs[i], i);

      // Round-robin: both held from the same cycle, each re-requests right after its ack
      a.cpu_we = 1; a.cpu_addr = 15'h0100; a.cpu_wdata = 8'h11;
      a.ext_we = 1; a.ext_addr = 15'h0200; a.ext_wdata = 8'h22;
      a.cpu_req = 1; a.ext_req = 1;
      n = 0; order = '0;
      for (int c = 0; c < 60 && n < 4; c++) begin
         @(negedge clk);
         if (a.ram_we || a.ram_re) begin
            order[n] = a.owner;
            n++;
         end
      end
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         seen = a.cpu_ack | a.ext_ack;
      end
      @(posedge clk); #1;
      a.cpu_req = 0; a.ext_req = 0;
      chk("rr grant count", n, 4);
      chk("rr grant 0 owner", {31'd0, order[0]}, 32'd0);
      chk("rr grant 1 owner", {31'd0, order[1]}, 32'd1);
      chk("rr grant 2 owner", {31'd0, order[2]}, 32'd0);
      chk("rr grant 3 owner", {31'd0, order[3]}, 32'd1);
      chk("rr final ack seen", {31'd0, seen}, 32'd1);

      // ext_lock holds the CPU off while both request
      a.ext_lock = 1; a.cpu_req = 1; a.ext_req = 1;
      ext_acks = 0; cpu_grants = 0; stall_ok = 1'b1;
      for (int c = 0; c < 60 && ext_acks < 4; c++) begin
         @(negedge clk);
         if ((a.ram_we || a.ram_re) && !a.owner) cpu_grants++;
         if (a.ext_ack) ext_acks++;
         if (!a.cpu_stall) stall_ok = 1'b0;
      end
      @(posedge clk); #1;
      a.ext_lock = 0;
      got_own = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (a.ram_we || a.ram_re) begin
            seen = 1'b1;
            got_own = a.owner;
         end
      end
      for (int c = 0; c < 10 && !a.cpu_ack; c++) @(negedge clk);
      @(posedge clk); #1;
      a.cpu_req = 0; a.ext_req = 0;
      chk("lock ext acks", ext_acks, 4);
      chk("lock cpu grants", cpu_grants, 0);
      chk("lock cpu_stall held", {31'd0, stall_ok}, 32'd1);
      chk("unlock grant seen", {31'd0, seen}, 32'd1);
      chk("unlock grant owner", {31'd0, got_own}, 32'd0);

      // RD_LAT = 3 CPU read timing
      b.cpu_we = 0; b.cpu_addr = 15'h0100; b.cpu_req = 1;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         chk($sformatf("lat3 ram_re c%0d", c), {31'd0, b.ram_re}, {31'd0, c == 1});
         chk($sformatf("lat3 cpu_ack c%0d", c), {31'd0, b.cpu_ack}, {31'd0, c == 5});
         chk($sformatf("lat3 cpu_stall c%0d", c), {31'd0, b.cpu_stall}, {31'd0, c < 5});
         if (c == 4) chk("lat3 rdata before capture", {24'd0, b.cpu_rdata}, 32'h00);
         if (c == 5) chk("lat3 rdata at ack", {24'd0, b.cpu_rdata}, 32'h77);
      end
      @(posedge clk); #1;
      b.cpu_req = 0;

      // Reset during WAIT of a CPU read
      a.cpu_we = 0; a.cpu_addr = 15'h0010; a.cpu_req = 1;
      @(negedge clk);
      @(negedge clk);
      chk("rst-test strobe", {31'd0, a.ram_re}, 32'd1);
      @(negedge clk);
      chk("rst-test busy in wait", {31'd0, a.busy}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst-mid ram_re", {31'd0, a.ram_re}, 32'd0);
      chk("rst-mid busy", {31'd0, a.busy}, 32'd0);
      chk("rst-mid cpu_ack", {31'd0, a.cpu_ack}, 32'd0);
      chk("rst-mid cpu_rdata", {24'd0, a.cpu_rdata}, 32'd0);
      a.cpu_req = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      any_ack = 1'b0; any_busy = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         any_ack  = any_ack | a.cpu_ack | a.ext_ack;
         any_busy = any_busy | a.busy;
      end
      chk("post-reset no ack", {31'd0, any_ack}, 32'd0);
      chk("post-reset idle", {31'd0, any_busy}, 32'd0);
      @(posedge clk); #1;
      a.cpu_we = 1; a.cpu_addr = 15'h0300; a.cpu_wdata = 8'h33;
      a.ext_we = 1; a.ext_addr = 15'h0400; a.ext_wdata = 8'h44;
      a.cpu_req = 1; a.ext_req = 1;
      seen = 1'b0; got_own = 1'b1;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (a.ram_we || a.ram_re) begin
            seen = 1'b1;
            got_own = a.owner;
         end
      end
      for (int c = 0; c < 10 && !a.cpu_ack && !a.ext_ack; c++) @(negedge clk);
      @(posedge clk); #1;
      a.cpu_req = 0; a.ext_req = 0;
      chk("post-reset conflict seen", {31'd0, seen}, 32'd1);
      chk("post-reset conflict owner", {31'd0, got_own}, 32'd0);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port program/data RAM between two requesters: the processor datapath (MAR/MDR side) and an external loader/debug port.
- Sequences each access as a fixed grant → strobe → (read wait) → ack sequence.
- Arbitrates conflicts round-robin; supports a loader lock that holds the CPU off during program download.
- Drives the CPU stall signal the control unit uses to freeze its step counter.

Parameters:
- AW, 15: address width (matches the MAR/address bus).
- DW, 8: data width (matches RAM/MDR).
- RD_LAT, 1: RAM read latency in cycles after the strobe; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data (AC[7:0])
- cpu_rdata  out  DW  CPU read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/AW/DW  loader request fields, same rules as CPU
- ext_rdata  out  DW  loader read data
- ext_ack  out  1  loader completion pulse
- ext_lock  in  1  while high, only ext is granted
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_we  out  1  RAM write strobe
- ram_re  out  1  RAM read strobe
- ram_rdata  in  DW  RAM read data
- owner  out  1  0 = CPU, 1 = ext; owner of current or last access
- busy  out  1  state != IDLE

Behaviour:
- One clock, clk; asynchronous active-low reset rst_n.
- Reset (asynchronous, takes effect immediately, including mid-access):
  - state = IDLE; all outputs 0.
  - last_grant = ext, so the CPU wins the first conflict.
  - Any in-flight access is abandoned with no ack.
- States: IDLE, STROBE, WAIT, ACK.
- IDLE:
  - Samples requests; no request → stay in IDLE.
  - ext_lock = 1: grant ext only if ext_req; cpu_req is ignored.
  - ext_lock = 0, one request: grant it.
  - ext_lock = 0, both requests: grant the requester not in last_grant.
  - On grant: latch addr, we, wdata and owner; update last_grant; go to STROBE.
- STROBE (exactly 1 cycle):
  - ram_addr/ram_wdata driven from the latched values.
  - ram_we = latched we; ram_re = ~latched we.
  - Write → ACK. Read → WAIT with counter loaded to RD_LAT-1.
- WAIT:
  - Counter decrements each cycle.
  - ram_rdata is captured into the owner's rdata register on the cycle the counter reads 0 (strobe + RD_LAT); then go to ACK.
  - With RD_LAT = 1, WAIT lasts one cycle.
- ACK (1 cycle): the owner's ack = 1; then go to IDLE. Requests are not sampled in ACK.
- Requester contract:
  - Deassert req (or present a new request) in the cycle after ack.
  - req still high in IDLE after ack is a new request.
  - Request fields must stay stable from req rise until ack.
- Latency, request seen in IDLE at cycle G:
  - strobe at G+1.
  - Write ack at G+2.
  - Read ack at G+2+RD_LAT (G+3 at default).
  - Throughput: one write per 3 cycles, one read per 3+RD_LAT cycles.
- Output hold rules:
  - ram_we/ram_re are high only in STROBE.
  - ram_addr/ram_wdata hold their last value outside STROBE.
  - cpu_rdata/ext_rdata hold until the next read by the same requester; writes do not change them.
- ext_lock rising during a CPU access: that access completes and acks normally; lock affects only later grants.
- ext_lock falling: the next IDLE arbitration is normal round-robin.
- A request arriving while busy waits; there is no queueing beyond the held req.
- cpu_stall stays high through the whole CPU access and falls in the ack cycle.
- RD_LAT outside 1..7 is unsupported.

Test Plan:
- Reset then CPU write (addr 0x0010, data 0xA5) → ram_we high exactly 1 cycle at G+1, ram_addr = 0x0010, ram_wdata = 0xA5; cpu_ack at G+2; owner = 0.
- Ext write 0x3C to 0x7FFF, then ext read of 0x7FFF with RAM model RD_LAT = 1 → ext_ack at G+3, ext_rdata = 0x3C; cpu_rdata unchanged (0x00).
- Both requesters raise req in the same cycle after reset, each repeating immediately after its ack → grant order CPU, ext, CPU, ext; never two consecutive grants to one side.
- ext_lock = 1 with cpu_req and ext_req both held for 4 ext accesses → no CPU grants and cpu_stall stays 1; drop lock → CPU granted at the next IDLE.
- rst_n pulled low during WAIT of a CPU read → ram_re, busy and cpu_ack are 0 immediately; no ack after release; the next conflict goes to the CPU.
- RD_LAT = 3 build, CPU read → ram_re at G+1, data captured at G+4, cpu_ack at G+5; cpu_stall high G..G+4.
